mem_access_ctrl: RTL

//  Memory access controller between the CPU datapath/control unit and the synchronous ram.

---
 rtl/mem_if_pkg.sv | 13 +
 rtl/mar_mdr_regs.sv | 30 +++
 rtl/mem_access_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Shared types and defaults for the memory access controller.
package mem_if_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 9;
  localparam int LAT_W      = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2,
    WR_ISSUE = 2'd3
  } state_e;
endpackage

// File: rtl/mar_mdr_regs.sv
// MAR/MDR register pair; a ram capture into MDR takes priority over a bus load.
module mar_mdr_regs
  import mem_if_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic [DATA_W-1:0] bus,
  input  logic              mar_ld,
  input  logic              mdr_bus_ld,
  input  logic              mdr_mem_ld,
  input  logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mar,
  output logic [DATA_W-1:0] mdr
);

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      mar <= '0;
      mdr <= '0;
    end else begin
      if (mar_ld) mar <= bus[ADDR_W-1:0];
      if (mdr_mem_ld)      mdr <= mem_data;
      else if (mdr_bus_ld) mdr <= bus;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: sequences one ram read or write per request.
// Optional range check on MAR enabled by defining ADDR_CHECK_EN.
//
// state    | meaning
// IDLE     | waiting for mem_req
// RD_ISSUE | ram_read strobe high for one cycle
// RD_WAIT  | counting down the ram read latency
// WR_ISSUE | ram_write strobe high for one cycle
module mem_access_ctrl
  import mem_if_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int RD_LATENCY = 1,
  parameter int MEM_DEPTH  = 512
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [DATA_W-1:0] MDataIn,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic [DATA_W-1:0] MDR_q,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              mem_fault
);

  state_e             state, state_nxt;
  logic [LAT_W-1:0]   cnt, cnt_nxt;
  logic [ADDR_W-1:0]  mar;
  logic               accept, addr_bad, issue, capture;
  logic               read_nxt, write_nxt, done_nxt, mdr_bus_ld;

  assign accept = (state == IDLE) && mem_req;

`ifdef ADDR_CHECK_EN
  logic fault_q;
  assign addr_bad = int'(mar) >= MEM_DEPTH;
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) fault_q <= 1'b0;
    else          fault_q <= accept && addr_bad;
  end
  assign mem_fault = fault_q;
`else
  assign addr_bad  = 1'b0;
  assign mem_fault = 1'b0;
`endif

  assign issue = accept && !addr_bad;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
      mem_done  <= 1'b0;
      ram_addr  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ram_read  <= read_nxt;
      ram_write <= write_nxt;
      mem_done  <= done_nxt;
      if (issue) ram_addr <= mar;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:     if (issue) state_nxt = mem_we ? WR_ISSUE : RD_ISSUE;
      RD_ISSUE: begin
        state_nxt = RD_WAIT;
        cnt_nxt   = LAT_W'(RD_LATENCY);
      end
      RD_WAIT: begin
        cnt_nxt = cnt - LAT_W'(1);
        if (cnt == LAT_W'(1)) state_nxt = IDLE;
      end
      WR_ISSUE: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Next values for the registered strobes, plus the MDR load enables.
  always_comb begin
    capture    = (state == RD_WAIT) && (cnt == LAT_W'(1));
    read_nxt   = issue && !mem_we;
    write_nxt  = issue && mem_we;
    done_nxt   = capture || (state == WR_ISSUE) || (accept && addr_bad);
    mdr_bus_ld = MDRin && (state == IDLE) && !mem_req;
  end

  mar_mdr_regs #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_regs (
    .clock      (clock),
    .clear_n    (clear_n),
    .bus        (BusMuxOut),
    .mar_ld     (MARin),
    .mdr_bus_ld (mdr_bus_ld),
    .mdr_mem_ld (capture),
    .mem_data   (MDataIn),
    .mar        (mar),
    .mdr        (MDR_q)
  );

  assign ram_din  = MDR_q;
  assign mem_busy = (state != IDLE);

endmodule
